// File: rtl/async_port_receiver.sv
// Clocked responder for one asynchronous switch output port: resynchronizes the
// 4-phase request, captures bundled data into a FIFO and returns the acknowledge.
module async_port_receiver #(
  parameter int WIDTH       = 128,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gen_enable,
  input  logic                     req_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     ack_o,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         flit_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] req_sync_p0;
  logic                   req_s;
  state_t                 state;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   full;
  logic                   push;
  logic                   pop;

  assign req_s     = req_sync_p0[SYNC_STAGES-1];
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push      = (state == CAPTURE) && (!full || pop);
  assign occupancy = count;

  // Stage p0: request synchronizer (data_i is bundled, never synchronized)
  always_ff @(posedge clk) begin
    if (reset) begin
      req_sync_p0 <= '0;
    end else begin
      req_sync_p0 <= {req_sync_p0[SYNC_STAGES-2:0], req_i};
    end
  end

  // Stage p1: handshake FSM with registered acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ack_o      <= 1'b0;
      flit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_o <= 1'b0;
          if (req_s && gen_enable) state <= CAPTURE;
        end
        CAPTURE: begin
          if (push) begin
            ack_o      <= 1'b1;
            flit_count <= flit_count + CNT_W'(1);
            state      <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!req_s) begin
            ack_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage p2: FIFO storage and registered head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      // The head register is loaded with whatever becomes the oldest flit.
      if (push && ((count == '0) || (pop && count == (PTR_W+1)'(1)))) begin
        out_data <= data_i;
      end else if (pop && count > (PTR_W+1)'(1)) begin
        out_data <= mem[rd_ptr + PTR_W'(1)];
      end
    end
  end

endmodule

// File: tb/tb_async_port_receiver.sv
// Directed/randomized bench for async_port_receiver acting as the switch side of
// the 4-phase channel, with a queue-based scoreboard of accepted and popped flits.
module tb_async_port_receiver;

  localparam int WIDTH = 128;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 gen_enable;
  logic                 req_i;
  logic [WIDTH-1:0]     data_i;
  logic                 ack_o;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]     flit_count;

  async_port_receiver #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .gen_enable(gen_enable), .req_i(req_i),
    .data_i(data_i), .ack_o(ack_o), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy), .flit_count(flit_count)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] popped_q[$];
  int exp_cnt = 0;
  int base_exp = 0;
  int base_pop = 0;
  int exp_rd = 0;
  int pop_rd = 0;

  // Consumer side: record every flit the DUT hands over.
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) popped_q.push_back(out_data);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int model_occ();
    return (exp_q.size() - base_exp) - (popped_q.size() - base_pop);
  endfunction

  task automatic accept(input logic [WIDTH-1:0] d);
    exp_q.push_back(d);
    exp_cnt++;
  endtask

  task automatic wait_ack(input logic v, input int lim, input string tag);
    int n = 0;
    while (ack_o !== v && n < lim) begin
      tick();
      n++;
    end
    chk(tag, WIDTH'(ack_o), WIDTH'(v));
  endtask

  task automatic send_flit(input logic [WIDTH-1:0] d);
    data_i = d;
    req_i  = 1'b1;
    wait_ack(1'b1, 20, "ack_rise");
    accept(d);
    req_i = 1'b0;
    wait_ack(1'b0, 20, "ack_fall");
  endtask

  task automatic verify_pops();
    while (pop_rd < popped_q.size()) begin
      if (exp_rd < exp_q.size()) begin
        chk("pop_order", popped_q[pop_rd], exp_q[exp_rd]);
      end else begin
        chk("pop_extra", WIDTH'(pop_rd), WIDTH'(-1));
      end
      pop_rd++;
      exp_rd++;
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    verify_pops();
    chk("drain_occ", WIDTH'(occupancy), WIDTH'(model_occ()));
    chk("drain_empty", WIDTH'(occupancy), WIDTH'(0));
  endtask

  task automatic model_reset();
    exp_cnt  = 0;
    base_exp = exp_q.size();
    base_pop = popped_q.size();
    exp_rd   = exp_q.size();
    pop_rd   = popped_q.size();
  endtask

  initial begin
    logic [WIDTH-1:0] a5;
    logic [WIDTH-1:0] d;
    logic seen;
    a5 = {16{8'hA5}};
    reset = 1'b1; gen_enable = 1'b0; req_i = 1'b0; data_i = '0; out_ready = 1'b0;
    tick(); tick(); tick();
    model_reset();
    chk("rst_ack", WIDTH'(ack_o), WIDTH'(0));
    chk("rst_valid", WIDTH'(out_valid), WIDTH'(0));
    chk("rst_data", out_data, WIDTH'(0));
    chk("rst_occ", WIDTH'(occupancy), WIDTH'(0));
    chk("rst_cnt", WIDTH'(flit_count), WIDTH'(0));

    // Single flit with exact latency
    reset = 1'b0; gen_enable = 1'b1; data_i = a5; req_i = 1'b1;
    tick(); tick(); tick();
    chk("sf_ack_early", WIDTH'(ack_o), WIDTH'(0));
    tick();
    chk("sf_ack_edge3", WIDTH'(ack_o), WIDTH'(1));
    accept(a5);
    tick();
    chk("sf_valid", WIDTH'(out_valid), WIDTH'(1));
    chk("sf_data", out_data, a5);
    chk("sf_cnt", WIDTH'(flit_count), WIDTH'(exp_cnt % 16));
    req_i = 1'b0;
    tick(); tick();
    chk("sf_ack_hold", WIDTH'(ack_o), WIDTH'(1));
    tick();
    chk("sf_ack_drop", WIDTH'(ack_o), WIDTH'(0));
    drain();

    // Backpressure: four flits fill the FIFO, the fifth is held
    for (int i = 1; i <= 4; i++) send_flit(WIDTH'(i));
    chk("bp_occ4", WIDTH'(occupancy), WIDTH'(model_occ()));
    data_i = WIDTH'(5); req_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_held", WIDTH'(ack_o), WIDTH'(0));
    chk("bp_occ_held", WIDTH'(occupancy), WIDTH'(4));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ack5", WIDTH'(ack_o), WIDTH'(1));
    accept(WIDTH'(5));
    chk("bp_occ_after", WIDTH'(occupancy), WIDTH'(model_occ()));
    req_i = 1'b0;
    wait_ack(1'b0, 20, "bp_ack5_fall");
    drain();
    chk("bp_cnt", WIDTH'(flit_count), WIDTH'(exp_cnt % 16));

    // Full FIFO with continuous consumer: push and pop on one edge
    for (int i = 0; i < 4; i++) send_flit(rnd128());
    d = rnd128();
    data_i = d; req_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("fp_held", WIDTH'(ack_o), WIDTH'(0));
    out_ready = 1'b1;
    tick();
    chk("fp_ack", WIDTH'(ack_o), WIDTH'(1));
    chk("fp_occ", WIDTH'(occupancy), WIDTH'(4));
    accept(d);
    req_i = 1'b0;
    wait_ack(1'b0, 20, "fp_ack_fall");
    drain();
    chk("fp_pop_total", WIDTH'(popped_q.size() - base_pop), WIDTH'(exp_q.size() - base_exp));

    // gen_enable gating
    gen_enable = 1'b0;
    d = rnd128();
    data_i = d; req_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_o !== 1'b0) seen = 1'b1;
    end
    chk("gate_hold", WIDTH'(seen), WIDTH'(0));
    gen_enable = 1'b1;
    wait_ack(1'b1, SYNC + 2, "gate_release");
    accept(d);
    req_i = 1'b0;
    wait_ack(1'b0, 20, "gate_fall");
    drain();
    chk("gate_cnt", WIDTH'(flit_count), WIDTH'(exp_cnt % 16));

    // Reset in the middle of a handshake
    data_i = rnd128(); req_i = 1'b1;
    wait_ack(1'b1, 20, "mid_ack");
    reset = 1'b1; req_i = 1'b0;
    tick();
    model_reset();
    chk("mid_ack_clr", WIDTH'(ack_o), WIDTH'(0));
    chk("mid_occ", WIDTH'(occupancy), WIDTH'(0));
    chk("mid_cnt", WIDTH'(flit_count), WIDTH'(0));
    chk("mid_valid", WIDTH'(out_valid), WIDTH'(0));
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_idle", WIDTH'(ack_o), WIDTH'(0));

    // Counter wrap with a 4-bit counter
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_flit(rnd128());
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_cnt", WIDTH'(flit_count), WIDTH'(exp_cnt % 16));
    chk("wrap_cnt_one", WIDTH'(flit_count), WIDTH'(1));
    drain();
    chk("wrap_pop_total", WIDTH'(popped_q.size() - base_pop), WIDTH'(17));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
